// File: rtl/reducer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reducer_pkg                                                  |
// | Description : Operation encoding and helpers for the pipelined reducer.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package reducer_pkg;

    typedef enum logic [1:0] {
        OP_OR   = 2'd0,
        OP_AND  = 2'd1,
        OP_XOR  = 2'd2,
        OP_RSVD = 2'd3
    } reduce_op_t;

    // Identity bit of the operation; replicate across the word width.
    function automatic logic op_identity(input reduce_op_t op);
        return (op == OP_AND);
    endfunction

    function automatic logic op_apply(input reduce_op_t op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            default: return a | b;
        endcase
    endfunction

    // max(1, ceil(log_radix(count)))
    function automatic int stage_count(input int count, input int radix);
        int n;
        int cap;
        n   = 1;
        cap = radix;
        while (cap < count) begin
            cap = cap * radix;
            n   = n + 1;
        end
        return n;
    endfunction

    function automatic int stage_inputs(input int count, input int radix, input int stage);
        int n;
        n = count;
        for (int s = 0; s < stage; s++) begin
            n = (n + radix - 1) / radix;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_reducer_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reduce_stage                                                 |
// | Description : One tree level: chunk reduction by RADIX plus output regs.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reduce_stage
    import reducer_pkg::*;
#(
    parameter  int INPUTS  = 4,
    parameter  int WIDTH   = 8,
    parameter  int RADIX   = 4,
    localparam int OUTPUTS = (INPUTS + RADIX - 1) / RADIX
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_en,
    input  logic                             i_valid,
    input  reduce_op_t                       i_op,
    input  logic                             i_empty,
    input  logic [INPUTS-1:0][WIDTH-1:0]     i_data,
    output logic                             o_valid,
    output reduce_op_t                       o_op,
    output logic                             o_empty,
    output logic [OUTPUTS-1:0][WIDTH-1:0]    o_data
);

    localparam int c_PADDED = OUTPUTS * RADIX;

    logic [c_PADDED-1:0][WIDTH-1:0] w_pad;
    logic [OUTPUTS-1:0][WIDTH-1:0]  w_red;

    // The short final chunk is filled with the identity of this entry's op.
    for (genvar gi = 0; gi < c_PADDED; gi++) begin : g_pad
        if (gi < INPUTS) begin : g_lane
            assign w_pad[gi] = i_data[gi];
        end else begin : g_fill
            assign w_pad[gi] = {WIDTH{op_identity(i_op)}};
        end
    end

    always_comb begin
        w_red = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            w_red[o] = w_pad[o*RADIX];
            for (int r = 1; r < RADIX; r++) begin
                for (int b = 0; b < WIDTH; b++) begin
                    w_red[o][b] = op_apply(i_op, w_red[o][b], w_pad[o*RADIX+r][b]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_op    <= OP_OR;
            o_empty <= 1'b0;
            o_data  <= '0;
        end else if (i_en) begin
            o_valid <= i_valid;
            o_op    <= i_op;
            o_empty <= i_empty;
            o_data  <= w_red;
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_reducer_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : word_reducer_pipe                                            |
// | Description : Pipelined masked OR/AND/XOR word reducer with backpressure.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module word_reducer_pipe
    import reducer_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int WIDTH = 8,
    parameter int RADIX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  words_in [0:COUNT-1],
    input  logic [COUNT-1:0]  lane_mask,
    input  reduce_op_t        op,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  word_out,
    output logic              out_empty,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int STAGES = stage_count(COUNT, RADIX);

    logic                         w_en;
    logic [COUNT-1:0][WIDTH-1:0]  w_lanes;
    logic                         w_unused_op_parity;

    // One global enable: any stall at the output freezes the whole tree.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    always_comb begin
        w_lanes = '0;
        for (int i = 0; i < COUNT; i++) begin
            w_lanes[i] = lane_mask[i] ? words_in[i] : {WIDTH{op_identity(op)}};
        end
    end

    for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
        localparam int c_INS  = stage_inputs(COUNT, RADIX, gs);
        localparam int c_OUTS = (c_INS + RADIX - 1) / RADIX;

        logic [c_INS-1:0][WIDTH-1:0]  w_in;
        logic                         w_vin;
        logic                         w_ein;
        reduce_op_t                   w_oin;
        logic [c_OUTS-1:0][WIDTH-1:0] w_out;
        logic                         w_valid_q;
        logic                         w_empty_q;
        reduce_op_t                   w_op_q;

        if (gs == 0) begin : g_first
            assign w_in  = w_lanes;
            assign w_vin = in_valid && w_en;
            assign w_ein = (lane_mask == '0);
            assign w_oin = op;
        end else begin : g_next
            assign w_in  = g_stage[gs-1].w_out;
            assign w_vin = g_stage[gs-1].w_valid_q;
            assign w_ein = g_stage[gs-1].w_empty_q;
            assign w_oin = g_stage[gs-1].w_op_q;
        end

        reduce_stage #(
            .INPUTS (c_INS),
            .WIDTH  (WIDTH),
            .RADIX  (RADIX)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_en    (w_en),
            .i_valid (w_vin),
            .i_op    (w_oin),
            .i_empty (w_ein),
            .i_data  (w_in),
            .o_valid (w_valid_q),
            .o_op    (w_op_q),
            .o_empty (w_empty_q),
            .o_data  (w_out)
        );
    end

    assign word_out  = g_stage[STAGES-1].w_out[0];
    assign out_empty = g_stage[STAGES-1].w_empty_q;
    assign out_valid = g_stage[STAGES-1].w_valid_q;

    // The op copy leaving the last stage has no consumer.
    assign w_unused_op_parity = ^g_stage[STAGES-1].w_op_q;

endmodule
`default_nettype wire

// File: tb/tb_word_reducer_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_word_reducer_pipe                                         |
// | Description : Directed self-checking bench for word_reducer_pipe.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_word_reducer_pipe;
    import reducer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: COUNT=4, RADIX=4 (one stage)
    logic [7:0]  a_words [0:3];
    logic [3:0]  a_mask;
    reduce_op_t  a_op;
    logic        a_in_valid, a_in_ready, a_out_empty, a_out_valid, a_out_ready;
    logic [7:0]  a_word_out;

    // Instance B: COUNT=9, RADIX=2 (four stages)
    logic [7:0]  b_words [0:8];
    logic [8:0]  b_mask;
    reduce_op_t  b_op;
    logic        b_in_valid, b_in_ready, b_out_empty, b_out_valid, b_out_ready;
    logic [7:0]  b_word_out;

    word_reducer_pipe #(.COUNT(4), .WIDTH(8), .RADIX(4)) u_dut_a (
        .clk(clk), .reset(reset), .words_in(a_words), .lane_mask(a_mask), .op(a_op),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .word_out(a_word_out),
        .out_empty(a_out_empty), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    word_reducer_pipe #(.COUNT(9), .WIDTH(8), .RADIX(2)) u_dut_b (
        .clk(clk), .reset(reset), .words_in(b_words), .lane_mask(b_mask), .op(b_op),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .word_out(b_word_out),
        .out_empty(b_out_empty), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input reduce_op_t op, input logic [3:0] mask,
                          input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3);
        a_op       = op;
        a_mask     = mask;
        a_words    = '{w0, w1, w2, w3};
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got=%b exp=0", a_out_valid); end
        n_checks++; if (a_word_out !== 8'h00) begin n_fail++; $display("FAIL reset_a_word got=%h exp=00", a_word_out); end
        n_checks++; if (a_out_empty !== 1'b0) begin n_fail++; $display("FAIL reset_a_empty got=%b exp=0", a_out_empty); end
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got=%b exp=0", b_out_valid); end
        reset = 1'b0;
        step();
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready got=%b exp=1", a_in_ready); end
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready got=%b exp=1", b_in_ready); end
    endtask

    task automatic test_ops();
        a_send(OP_OR, 4'b1111, 8'h01, 8'h02, 8'h04, 8'h80);
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL or_valid got=%b exp=1", a_out_valid); end
        n_checks++; if (a_word_out !== 8'h87) begin n_fail++; $display("FAIL or_word got=%h exp=87", a_word_out); end
        n_checks++; if (a_out_empty !== 1'b0) begin n_fail++; $display("FAIL or_empty got=%b exp=0", a_out_empty); end
        a_send(OP_AND, 4'b0101, 8'hF0, 8'h0A, 8'h3C, 8'h05);
        n_checks++; if (a_word_out !== 8'h30) begin n_fail++; $display("FAIL and_word got=%h exp=30", a_word_out); end
        a_send(OP_XOR, 4'b1111, 8'hFF, 8'h0F, 8'hF0, 8'h01);
        n_checks++; if (a_word_out !== 8'h01) begin n_fail++; $display("FAIL xor_word got=%h exp=01", a_word_out); end
        a_send(OP_RSVD, 4'b1011, 8'h01, 8'h02, 8'h04, 8'h80);
        n_checks++; if (a_word_out !== 8'h83) begin n_fail++; $display("FAIL rsvd_word got=%h exp=83", a_word_out); end
        step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_empty();
        a_send(OP_AND, 4'b0000, 8'h00, 8'h11, 8'h22, 8'h33);
        n_checks++; if (a_word_out !== 8'hFF) begin n_fail++; $display("FAIL empty_and_word got=%h exp=ff", a_word_out); end
        n_checks++; if (a_out_empty !== 1'b1) begin n_fail++; $display("FAIL empty_and_flag got=%b exp=1", a_out_empty); end
        a_send(OP_OR, 4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        n_checks++; if (a_word_out !== 8'h00) begin n_fail++; $display("FAIL empty_or_word got=%h exp=00", a_word_out); end
        n_checks++; if (a_out_empty !== 1'b1) begin n_fail++; $display("FAIL empty_or_flag got=%b exp=1", a_out_empty); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_word [0:2];
        exp_word = '{8'hFF, 8'h77, 8'hFE};
        for (int c = 0; c < 8; c++) begin
            b_in_valid = (c < 3);
            case (c)
                0: begin b_op = OP_OR;  b_mask = 9'h1FF;
                         b_words = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h00}; end
                1: begin b_op = OP_AND; b_mask = 9'h1FE;
                         b_words = '{8'h00,8'hF7,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'h7F}; end
                2: begin b_op = OP_XOR; b_mask = 9'h1FF;
                         b_words = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h01}; end
                default: ;
            endcase
            step();
            if (c >= 3 && c <= 5) begin
                n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid edge=%0d got=%b exp=1", c+1, b_out_valid); end
                n_checks++; if (b_word_out !== exp_word[c-3]) begin n_fail++; $display("FAIL b2b_word edge=%0d got=%h exp=%h", c+1, b_word_out, exp_word[c-3]); end
            end else begin
                n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle edge=%0d got=%b exp=0", c+1, b_out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] q [$];
        logic [7:0] frozen;
        logic       acc;
        int         sent = 0;
        int         recv = 0;
        frozen = 8'h00;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            a_out_ready = !(cyc >= 3 && cyc < 8);
            a_in_valid  = (sent < 10);
            a_op        = OP_OR;
            a_mask      = 4'b0001;
            a_words     = '{8'(8'h10 + sent), 8'hFF, 8'hFF, 8'hFF};
            #1;
            if (cyc == 3) begin
                frozen = a_word_out;
                n_checks++; if (a_word_out !== 8'h12) begin n_fail++; $display("FAIL stall_head got=%h exp=12", a_word_out); end
            end
            if (cyc >= 3 && cyc < 8) begin
                n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", cyc, a_in_ready); end
                n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", cyc, a_out_valid); end
                if (cyc > 3) begin
                    n_checks++; if (a_word_out !== frozen) begin n_fail++; $display("FAIL stall_frozen cyc=%0d got=%h exp=%h", cyc, a_word_out, frozen); end
                end
            end
            if (a_out_valid && a_out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra got=%h exp=none", a_word_out);
                end else begin
                    if (a_word_out !== q[0]) begin n_fail++; $display("FAIL bp_seq got=%h exp=%h", a_word_out, q[0]); end
                    void'(q.pop_front());
                end
                recv++;
            end
            acc = a_in_valid && a_in_ready;
            @(posedge clk);
            if (acc) begin
                q.push_back(8'(8'h10 + sent));
                sent++;
            end
            #1;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        n_checks++; if (recv !== 10) begin n_fail++; $display("FAIL bp_count got=%0d exp=10", recv); end
        step();
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_reset_in_flight();
        b_out_ready = 1'b1;
        b_op        = OP_OR;
        b_mask      = 9'h1FF;
        b_words     = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h00};
        b_in_valid  = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset      = 1'b0;
        b_in_valid = 1'b0;
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight_valid got=%b exp=0", b_out_valid); end
        n_checks++; if (b_word_out !== 8'h00) begin n_fail++; $display("FAIL rst_flight_word got=%h exp=00", b_word_out); end
        for (int c = 0; c < 8; c++) begin
            step();
            n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale edge=%0d got=%b exp=0", c, b_out_valid); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0; a_out_ready = 1'b1; a_op = OP_OR; a_mask = '0;
        a_words     = '{default: 8'h00};
        b_in_valid  = 1'b0; b_out_ready = 1'b1; b_op = OP_OR; b_mask = '0;
        b_words     = '{default: 8'h00};
        test_reset();
        test_ops();
        test_empty();
        test_back_to_back();
        test_backpressure();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
